// File: rtl/ripple_count_monitor.sv
// Synchronizes and debounces an asynchronous ripple-counter code, extends it to a wide
// event counter and offers a one-deep snapshot. Optional compare: `define RIPPLE_MON_MATCH_EN.
module ripple_count_monitor #(
  parameter int WIDTH         = 4,
  parameter int EXT_WIDTH     = 16,
  parameter int STABLE_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     cnt_in,
  input  logic                 clr,
  input  logic [EXT_WIDTH-1:0] cmp_val,
  input  logic                 snap_req,
  input  logic                 snap_ready,
  output logic [WIDTH-1:0]     cnt_sync,
  output logic [EXT_WIDTH-1:0] ext_cnt,
  output logic                 wrap_pulse,
  output logic                 match_pulse,
  output logic                 snap_valid,
  output logic [EXT_WIDTH-1:0] snap_data
);

  typedef enum logic {SETTLE, STABLE} filt_state_t;
  typedef enum logic {EMPTY, FULL} snap_state_t;

  localparam logic [2:0] RUN_LAST = 3'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0]     s1, s2, s3;
  logic [2:0]           run_cnt;
  filt_state_t          filt_st;
  snap_state_t          snap_st;
  logic                 same_code;
  logic                 accept;
  logic [WIDTH-1:0]     delta;
  logic [EXT_WIDTH-1:0] delta_ext;

  // s1 == s2 before an edge is exactly s2 == s3 after it, so the run counter
  // advances on the edge at which s2 and s3 become equal.
  assign same_code = (s1 == s2);
  assign accept    = (filt_st == SETTLE) && same_code && (run_cnt == RUN_LAST);
  assign delta     = s2 - cnt_sync;
  assign delta_ext = EXT_WIDTH'(delta);

  // NOTE: all state below uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would chain s1->s2->s3 in a single cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1         <= '0;
      s2         <= '0;
      s3         <= '0;
      run_cnt    <= '0;
      filt_st    <= SETTLE;
      cnt_sync   <= '0;
      ext_cnt    <= '0;
      wrap_pulse <= 1'b0;
    end else begin
      s1         <= cnt_in;
      s2         <= s1;
      s3         <= s2;
      wrap_pulse <= 1'b0;

      case (filt_st)
        SETTLE: begin
          if (!same_code) begin
            run_cnt <= '0;
          end else if (run_cnt == RUN_LAST) begin
            run_cnt    <= '0;
            filt_st    <= STABLE;
            cnt_sync   <= s2;
            wrap_pulse <= (s2 < cnt_sync);
          end else begin
            run_cnt <= run_cnt + 3'd1;
          end
        end
        STABLE: begin
          if (!same_code) filt_st <= SETTLE;
        end
        default: filt_st <= SETTLE;
      endcase

      // clr keeps cnt_sync as the new baseline and discards a coincident delta
      if (clr)         ext_cnt <= '0;
      else if (accept) ext_cnt <= ext_cnt + delta_ext;
    end
  end

`ifdef RIPPLE_MON_MATCH_EN
  logic ext_upd;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ext_upd     <= 1'b0;
      match_pulse <= 1'b0;
    end else begin
      // A write of ext_cnt (clr or a real step) arms one compare on the next edge
      ext_upd     <= clr || (accept && (s2 != cnt_sync));
      match_pulse <= ext_upd && (ext_cnt == cmp_val);
    end
  end
`else
  logic unused_cmp;
  assign unused_cmp  = ^cmp_val;
  assign match_pulse = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snap_st    <= EMPTY;
      snap_valid <= 1'b0;
      snap_data  <= '0;
    end else begin
      case (snap_st)
        EMPTY: begin
          if (snap_req) begin
            snap_data  <= ext_cnt;
            snap_valid <= 1'b1;
            snap_st    <= FULL;
          end
        end
        FULL: begin
          // requests while full are dropped, even on the handshake cycle
          if (snap_ready) begin
            snap_valid <= 1'b0;
            snap_st    <= EMPTY;
          end
        end
        default: snap_st <= EMPTY;
      endcase
    end
  end

  logic unused_s3;
  assign unused_s3 = ^s3;

endmodule
